// File: rtl/floppy_step_driver.sv
// floppy_step_driver: turns a step-period setpoint into a STEP pulse train
// for one floppy drive, tracks the head and bounces DIR at the track limits.
// Ports: clk, rst (async, active low), sp (period in clocks, 0 = silent),
//        en (note enable), step_n (STEP, active low), dir_n (0 = inward),
//        track (head position estimate), busy (high while homing).

module floppy_step_driver #(
    parameter int SP_W    = 22,
    parameter int TRACKS  = 80,
    parameter int STEP_W  = 50,
    parameter int HOME_SP = 500000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SP_W-1:0] sp,
    input  logic            en,
    output logic            step_n,
    output logic            dir_n,
    output logic [6:0]      track,
    output logic            busy
);

    localparam int PW = $clog2(STEP_W + 1);

    localparam logic [SP_W-1:0] MIN_SP  = SP_W'(2 * STEP_W);
    localparam logic [SP_W-1:0] HOME_TC = SP_W'(HOME_SP - 1);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [PW-1:0]   PW_LAST = PW'(STEP_W - 1);
    localparam logic [PW-1:0]   PW_ONE  = PW'(1);
    localparam logic [6:0]      TRK_MAX = 7'(TRACKS - 1);
    localparam logic [6:0]      HOME_N  = 7'(TRACKS);

    typedef enum logic [1:0] {
        S_HOME,
        S_IDLE,
        S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [SP_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [6:0]      hcnt_q, hcnt_d;
    logic            step_n_q, step_n_d;
    logic            dir_n_q, dir_n_d;
    logic [6:0]      track_q, track_d;
    logic            busy_q, busy_d;

    logic [SP_W-1:0] eff_sp;
    logic [SP_W-1:0] run_tc;
    logic            pulse_on;
    logic            pulse_end;
    logic            go;

    // Short setpoints are stretched so STEP always gets a high phase
    // at least as long as its low phase.
    assign eff_sp    = (sp < MIN_SP) ? MIN_SP : sp;
    assign run_tc    = eff_sp - SP_ONE;
    assign pulse_on  = !step_n_q;
    assign pulse_end = pulse_on && (pcnt_q == PW_LAST);
    assign go        = en && (sp != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        hcnt_d   = hcnt_q;
        step_n_d = step_n_q;
        dir_n_d  = dir_n_q;
        track_d  = track_q;
        busy_d   = busy_q;

        // Low-phase timer runs whatever the state, so a pulse in
        // flight always completes its full width.
        if (pulse_on) begin
            if (pulse_end) begin
                step_n_d = 1'b1;
                pcnt_d   = '0;
            end else begin
                pcnt_d = pcnt_q + PW_ONE;
            end
        end

        unique case (state_q)
            S_HOME: begin
                busy_d  = 1'b1;
                dir_n_d = 1'b1;
                if (pulse_end && hcnt_q == HOME_N) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    dir_n_d = 1'b0;
                    track_d = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q >= HOME_TC) begin
                    cnt_d = '0;
                    if (hcnt_q != HOME_N) begin
                        step_n_d = 1'b0;
                        pcnt_d   = '0;
                        hcnt_d   = hcnt_q + 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q + SP_ONE;
                end
            end

            S_IDLE: begin
                cnt_d = '0;
                if (go) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // Reverse only as STEP returns high, using the track
                // value already advanced by this pulse.
                if (pulse_end) begin
                    if (!dir_n_q && track_q == TRK_MAX) begin
                        dir_n_d = 1'b1;
                    end else if (dir_n_q && track_q == '0) begin
                        dir_n_d = 1'b0;
                    end
                end
                if (!go) begin
                    cnt_d = '0;
                    if (!pulse_on) begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q >= run_tc) begin
                    // '>=' also catches a counter left beyond a lowered
                    // setpoint and wraps it straight into a pulse.
                    cnt_d    = '0;
                    step_n_d = 1'b0;
                    pcnt_d   = '0;
                    if (!dir_n_q) begin
                        if (track_q != TRK_MAX) begin
                            track_d = track_q + 7'd1;
                        end
                    end else if (track_q != '0) begin
                        track_d = track_q - 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q + SP_ONE;
                end
            end

            default: begin
                state_d = S_HOME;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_HOME;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            step_n_q <= 1'b1;
            dir_n_q  <= 1'b1;
            track_q  <= '0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            step_n_q <= step_n_d;
            dir_n_q  <= dir_n_d;
            track_q  <= track_d;
            busy_q   <= busy_d;
        end
    end

    assign step_n = step_n_q;
    assign dir_n  = dir_n_q;
    assign track  = track_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_floppy_step_driver.sv
// tb_floppy_step_driver: scenario tasks plus randomized runs, checked
// against a timing/bounce model computed from the pulse-train rules.

module tb_floppy_step_driver;

    localparam int SP_W    = 22;
    localparam int TRACKS  = 4;
    localparam int STEP_W  = 2;
    localparam int HOME_SP = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic [SP_W-1:0] sp  = '0;
    logic            step_n;
    logic            dir_n;
    logic [6:0]      track;
    logic            busy;

    int total = 0;
    int bad   = 0;
    int pcyc  = 0;

    int fall_t[$];
    int fall_trk[$];
    int fall_dir[$];
    int fall_busy[$];
    int wid[$];
    int last_fall = 0;
    bit prev_sn   = 1'b1;

    int m_track = 0;
    int m_dir   = 0;

    floppy_step_driver #(
        .SP_W   (SP_W),
        .TRACKS (TRACKS),
        .STEP_W (STEP_W),
        .HOME_SP(HOME_SP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sp    (sp),
        .en    (en),
        .step_n(step_n),
        .dir_n (dir_n),
        .track (track),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // pcyc = index of the last rising edge; events are stamped with it
    always @(posedge clk) begin
        #1;
        pcyc++;
        if (prev_sn && !step_n) begin
            fall_t.push_back(pcyc);
            fall_trk.push_back(int'(track));
            fall_dir.push_back(int'(dir_n));
            fall_busy.push_back(int'(busy));
            last_fall = pcyc;
        end
        if (!prev_sn && step_n) begin
            wid.push_back(pcyc - last_fall);
        end
        prev_sn = step_n;
    end

    initial begin
        #500000;
        $display("FAIL watchdog no finish");
        $fatal(1);
    end

    function automatic int eff(int s);
        return (s < 2 * STEP_W) ? 2 * STEP_W : s;
    endfunction

    // head bounces between 0 and TRACKS-1
    function automatic void m_step();
        if (m_dir == 0) begin
            if (m_track < TRACKS - 1) m_track++;
            if (m_track == TRACKS - 1) m_dir = 1;
        end else begin
            if (m_track > 0) m_track--;
            if (m_track == 0) m_dir = 0;
        end
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        fall_t.delete();
        fall_trk.delete();
        fall_dir.delete();
        fall_busy.delete();
        wid.delete();
    endtask

    task automatic test_reset();
        int r;
        int t0;
        en = 1'b0;
        sp = '0;
        #2 rst = 1'b0;
        tick(3);
        total++;
        if (step_n !== 1'b1 || dir_n !== 1'b1 || track !== 7'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_vals got=%b%b%0d%b want=1 1 0 1",
                     step_n, dir_n, track, busy);
        end
        clr();
        r = pcyc;
        rst = 1'b1;
        t0 = -1;
        for (int i = 0; i < 200 && t0 < 0; i++) begin
            tick(1);
            if (!busy) t0 = pcyc;
        end
        total++;
        if (t0 !== r + TRACKS * HOME_SP + STEP_W) begin
            bad++;
            $display("FAIL home_done got=%0d want=%0d", t0 - r,
                     TRACKS * HOME_SP + STEP_W);
        end
        total++;
        if (fall_t.size() != TRACKS) begin
            bad++;
            $display("FAIL home_count got=%0d want=%0d", fall_t.size(), TRACKS);
        end
        for (int i = 0; i < TRACKS && i < fall_t.size(); i++) begin
            total++;
            if (fall_t[i] !== r + (i + 1) * HOME_SP ||
                (i < wid.size() ? wid[i] : -1) !== STEP_W ||
                fall_dir[i] !== 1 || fall_busy[i] !== 1 || fall_trk[i] !== 0) begin
                bad++;
                $display("FAIL home_pulse%0d got t=%0d w=%0d d=%0d b=%0d want t=%0d w=%0d d=1 b=1",
                         i, fall_t[i] - r, (i < wid.size() ? wid[i] : -1),
                         fall_dir[i], fall_busy[i], (i + 1) * HOME_SP, STEP_W);
            end
        end
        total++;
        if (dir_n !== 1'b0 || track !== 7'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL home_after got dir=%b trk=%0d busy=%b want 0 0 0",
                     dir_n, track, busy);
        end
        m_track = 0;
        m_dir   = 0;
    endtask

    task automatic test_bounce();
        int d, k, e, s, n_exp, ed;
        clr();
        d = pcyc;
        e = eff(8);
        k = d + 1;
        sp = SP_W'(8);
        en = 1'b1;
        tick(60);
        s = pcyc;
        en = 1'b0;
        tick(10);
        n_exp = (s - k) / e;
        total++;
        if (fall_t.size() != n_exp) begin
            bad++;
            $display("FAIL bounce_count got=%0d want=%0d", fall_t.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < fall_t.size(); i++) begin
            ed = m_dir;
            m_step();
            total++;
            if (fall_t[i] !== k + (i + 1) * e || fall_trk[i] !== m_track ||
                fall_dir[i] !== ed || (i < wid.size() ? wid[i] : -1) !== STEP_W) begin
                bad++;
                $display("FAIL bounce%0d got t=%0d trk=%0d dir=%0d want t=%0d trk=%0d dir=%0d",
                         i, fall_t[i] - k, fall_trk[i], fall_dir[i],
                         (i + 1) * e, m_track, ed);
            end
        end
        total++;
        if (int'(track) !== m_track || int'(dir_n) !== m_dir) begin
            bad++;
            $display("FAIL bounce_end got trk=%0d dir=%b want trk=%0d dir=%0d",
                     track, dir_n, m_track, m_dir);
        end
    endtask

    task automatic test_clamp_silence();
        int d, k, e, s, n_exp;
        clr();
        d = pcyc;
        e = eff(1);
        k = d + 1;
        sp = SP_W'(1);
        en = 1'b1;
        tick(25);
        s = pcyc;
        sp = '0;
        tick(20);
        n_exp = (s - k) / e;
        total++;
        if (fall_t.size() != n_exp) begin
            bad++;
            $display("FAIL clamp_count got=%0d want=%0d", fall_t.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < fall_t.size(); i++) begin
            m_step();
            total++;
            if (fall_t[i] !== k + (i + 1) * e || fall_trk[i] !== m_track ||
                (i < wid.size() ? wid[i] : -1) !== STEP_W) begin
                bad++;
                $display("FAIL clamp%0d got t=%0d trk=%0d want t=%0d trk=%0d",
                         i, fall_t[i] - k, fall_trk[i], (i + 1) * e, m_track);
            end
        end
        total++;
        if (step_n !== 1'b1 || int'(track) !== m_track) begin
            bad++;
            $display("FAIL silent_hold got step=%b trk=%0d want 1 %0d",
                     step_n, track, m_track);
        end
        en = 1'b0;
        tick(4);
    endtask

    task automatic test_en_drop();
        int d, k, s, f;
        clr();
        d = pcyc;
        k = d + 1;
        sp = SP_W'(6);
        en = 1'b1;
        f = -1;
        for (int i = 0; i < 50 && f < 0; i++) begin
            tick(1);
            if (!step_n) f = pcyc;
        end
        en = 1'b0;
        tick(15);
        m_step();
        total++;
        if (f !== k + 6 || fall_t.size() != 1 || wid.size() != 1 ||
            (wid.size() > 0 ? wid[0] : -1) !== STEP_W || int'(track) !== m_track) begin
            bad++;
            $display("FAIL en_drop got fall=%0d n=%0d w=%0d trk=%0d want fall=6 n=1 w=%0d trk=%0d",
                     f - k, fall_t.size(), (wid.size() > 0 ? wid[0] : -1),
                     track, STEP_W, m_track);
        end
        clr();
        d = pcyc;
        k = d + 1;
        en = 1'b1;
        tick(10);
        s = pcyc;
        en = 1'b0;
        tick(10);
        m_step();
        total++;
        if (fall_t.size() != (s - k) / 6 ||
            (fall_t.size() > 0 ? fall_t[0] : -1) !== k + 6 ||
            (fall_trk.size() > 0 ? fall_trk[0] : -1) !== m_track) begin
            bad++;
            $display("FAIL en_restart got n=%0d t=%0d want n=%0d t=6 trk=%0d",
                     fall_t.size(), (fall_t.size() > 0 ? fall_t[0] - k : -1),
                     (s - k) / 6, m_track);
        end
    endtask

    task automatic test_sp_lower();
        int d, k, s, first, n_exp;
        clr();
        d = pcyc;
        k = d + 1;
        sp = SP_W'(20);
        en = 1'b1;
        tick(13);
        sp = SP_W'(5);
        tick(12);
        s = pcyc;
        en = 1'b0;
        tick(10);
        first = k + 13;
        n_exp = (s - first) / eff(5) + 1;
        total++;
        if (fall_t.size() != n_exp) begin
            bad++;
            $display("FAIL lower_count got=%0d want=%0d", fall_t.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < fall_t.size(); i++) begin
            m_step();
            total++;
            if (fall_t[i] !== first + i * eff(5) || fall_trk[i] !== m_track) begin
                bad++;
                $display("FAIL lower%0d got t=%0d trk=%0d want t=%0d trk=%0d",
                         i, fall_t[i] - k, fall_trk[i], first + i * eff(5) - k, m_track);
            end
        end
    endtask

    task automatic test_random();
        int d, k, e, s, n_exp, spv, dur, ed;
        for (int r = 0; r < 6; r++) begin
            clr();
            spv = int'($urandom_range(1, 14));
            dur = int'($urandom_range(10, 50));
            e = eff(spv);
            d = pcyc;
            k = d + 1;
            sp = SP_W'(spv);
            en = 1'b1;
            tick(dur);
            s = pcyc;
            if ($urandom_range(0, 1) == 0) en = 1'b0;
            else sp = '0;
            tick(10);
            n_exp = (s - k) / e;
            total++;
            if (fall_t.size() != n_exp) begin
                bad++;
                $display("FAIL rnd%0d_count sp=%0d got=%0d want=%0d",
                         r, spv, fall_t.size(), n_exp);
            end
            for (int i = 0; i < n_exp && i < fall_t.size(); i++) begin
                ed = m_dir;
                m_step();
                total++;
                if (fall_t[i] !== k + (i + 1) * e || fall_trk[i] !== m_track ||
                    fall_dir[i] !== ed || (i < wid.size() ? wid[i] : -1) !== STEP_W) begin
                    bad++;
                    $display("FAIL rnd%0d_p%0d sp=%0d got t=%0d trk=%0d want t=%0d trk=%0d",
                             r, i, spv, fall_t[i] - k, fall_trk[i], (i + 1) * e, m_track);
                end
            end
            en = 1'b0;
            sp = '0;
            tick(2);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int r, t0, found, s, n_exp, j;
        sp = SP_W'(4);
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick(1);
            if (!step_n && track == 7'd2) found = 1;
        end
        rst = 1'b0;
        #1;
        total++;
        if (found != 1 || step_n !== 1'b1 || track !== 7'd0 ||
            busy !== 1'b1 || dir_n !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid got found=%0d step=%b trk=%0d busy=%b dir=%b want 1 1 0 1 1",
                     found, step_n, track, busy, dir_n);
        end
        tick(3);
        clr();
        r = pcyc;
        rst = 1'b1;
        t0 = -1;
        for (int i = 0; i < 200 && t0 < 0; i++) begin
            tick(1);
            if (!busy) t0 = pcyc;
        end
        total++;
        if (t0 !== r + TRACKS * HOME_SP + STEP_W) begin
            bad++;
            $display("FAIL rehome_done got=%0d want=%0d", t0 - r,
                     TRACKS * HOME_SP + STEP_W);
        end
        for (int i = 0; i < TRACKS; i++) begin
            total++;
            if (i >= fall_t.size() || fall_t[i] !== r + (i + 1) * HOME_SP ||
                fall_busy[i] !== 1 || fall_dir[i] !== 1) begin
                bad++;
                $display("FAIL rehome_pulse%0d got t=%0d want t=%0d", i,
                         (i < fall_t.size() ? fall_t[i] - r : -1), (i + 1) * HOME_SP);
            end
        end
        tick(11);
        s = pcyc;
        en = 1'b0;
        tick(10);
        m_track = 0;
        m_dir   = 0;
        n_exp = (s - (t0 + 1)) / eff(4);
        total++;
        if (fall_t.size() != TRACKS + n_exp) begin
            bad++;
            $display("FAIL post_home_count got=%0d want=%0d",
                     fall_t.size() - TRACKS, n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            j = TRACKS + i;
            m_step();
            total++;
            if (j >= fall_t.size() || fall_t[j] !== t0 + 1 + (i + 1) * eff(4) ||
                fall_trk[j] !== m_track) begin
                bad++;
                $display("FAIL post_home%0d got t=%0d want t=%0d trk=%0d", i,
                         (j < fall_t.size() ? fall_t[j] - t0 : -1),
                         1 + (i + 1) * eff(4), m_track);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clamp_silence();
        test_en_drop();
        test_sp_lower();
        test_random();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
